// File: rtl/arbiter_root_grant.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_root_grant
// Brief    : Root grant controller for a tree of two-input round-robin
//            arbiters. Issues a zero-latency grant when downstream is ready
//            and a credit is free, with optional minimum grant spacing,
//            drain mode, overflow detection and a grant counter.
// Revision : 1.0 - initial release
// ============================================================================
module arbiter_root_grant #(
  parameter int CREDITS  = 4,
  parameter int CREDIT_W = $clog2(CREDITS + 1),
  parameter int MIN_GAP  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arb_req,
  output logic                arb_grant,
  input  logic                dn_ready,
  output logic                dn_valid,
  input  logic                rsp_valid,
  input  logic                enable,
  output logic [CREDIT_W-1:0] credits_avail,
  output logic                idle,
  output logic                err_overflow,
  output logic [31:0]         grant_count
);

  // Gap counter is sized for the largest legal MIN_GAP (15).
  localparam int                  GAP_W       = 4;
  localparam logic [GAP_W-1:0]    GAP_LOAD    = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0]    GAP_ONE     = GAP_W'(1);
  localparam logic                HAS_GAP     = (MIN_GAP > 0);
  localparam logic [CREDIT_W-1:0] CREDITS_MAX = CREDIT_W'(CREDITS);
  localparam logic [CREDIT_W-1:0] CREDIT_ONE  = CREDIT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GAP   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q,   state_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic                err_q,     err_d;
  logic [31:0]         gcnt_q,    gcnt_d;
  logic                w_grant;

  // Grant is purely combinational from registered state; a response in the
  // same cycle cannot enable a grant, and reset kills the grant at once.
  assign w_grant = arb_req & dn_ready & (state_q == ST_RUN) & enable &
                   (credits_q != '0) & ~rst;

  assign arb_grant     = w_grant;
  assign dn_valid      = w_grant;
  assign credits_avail = credits_q;
  assign idle          = (credits_q == CREDITS_MAX) && (state_q != ST_GAP);
  assign err_overflow  = err_q;
  assign grant_count   = gcnt_q;

  // State register and all datapath registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      gap_cnt_q <= '0;
      credits_q <= CREDITS_MAX;
      err_q     <= 1'b0;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      gcnt_q    <= gcnt_d;
    end
  end

  // Next-state logic: RUN issues grants, GAP enforces spacing, DRAIN blocks.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (!enable) begin
          state_d   = ST_DRAIN;
          gap_cnt_d = '0;
        end else if (w_grant && HAS_GAP) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (!enable) begin
          state_d   = ST_DRAIN;
          gap_cnt_d = '0;
        end else if (gap_cnt_q <= GAP_ONE) begin
          // Last forced idle cycle; a zero count is treated the same so the
          // machine can never stall in GAP.
          state_d   = ST_RUN;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      ST_DRAIN: begin
        gap_cnt_d = '0;
        if (enable) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_RUN;
        gap_cnt_d = '0;
      end
    endcase
  end

  // Credit accounting: grant consumes, response returns, both cancel out.
  // A response with nothing outstanding saturates and flags a sticky error.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (w_grant && !rsp_valid) begin
      credits_d = credits_q - CREDIT_ONE;
    end else if (!w_grant && rsp_valid) begin
      if (credits_q == CREDITS_MAX) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CREDIT_ONE;
      end
    end
  end

  // Free-running grant statistic, wrapping naturally at 2^32.
  always_comb begin
    gcnt_d = gcnt_q;
    if (w_grant) begin
      gcnt_d = gcnt_q + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/arbiter_root_grant.md
# arbiter_root_grant

Root grant controller for a tree of two-input round-robin arbiters. It takes the single aggregated request from the top arbiter and issues the grant that propagates back down the tree. It issues a grant only when the downstream request channel is ready and a credit is available, so the number of outstanding requests is bounded. Credits return on downstream responses. The block adds optional minimum grant spacing, a drain mode and statistics.

## Interface

Parameters:
- CREDITS, 4, maximum outstanding downstream requests; range 1..255
- CREDIT_W, $clog2(CREDITS+1), width of the credit counter
- MIN_GAP, 0, idle cycles forced after each grant; range 0..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- arb_req  in  1  OR of all leaf requests, from the top-level arbiter
- arb_grant  out  1  grant to the top-level arbiter
- dn_ready  in  1  downstream channel can accept a request this cycle
- dn_valid  out  1  request issued downstream; identical to arb_grant
- rsp_valid  in  1  one downstream response completed; returns one credit
- enable  in  1  when low, no new grants are issued (drain)
- credits_avail  out  CREDIT_W  registered count of free credits
- idle  out  1  high when credits_avail == CREDITS and state is not GAP
- err_overflow  out  1  sticky; set when a response arrives with no outstanding request
- grant_count  out  32  registered count of grants issued; wraps modulo 2^32

## Operation

- State machine has three states: RUN, GAP, DRAIN. The reset state is RUN.
- Grant condition is arb_grant = arb_req & dn_ready & (state==RUN) & enable & (credits != 0) & !rst.
  - arb_grant is combinational.
  - It uses only the registered credits and state, never rsp_valid in the same cycle.
- Credit update, per cycle:
  - grant only: credits − 1
  - rsp_valid only: credits + 1
  - both: unchanged
  - neither: unchanged
- Overflow: rsp_valid with credits == CREDITS and no grant in that cycle.
  - err_overflow is set.
  - credits stay at CREDITS (saturate).
  - err_overflow clears only on rst.
- RUN transitions:
  - grant with MIN_GAP > 0 goes to GAP and loads gap_cnt = MIN_GAP.
  - grant with MIN_GAP == 0 stays in RUN, allowing back-to-back grants.
  - enable low goes to DRAIN.
- GAP transitions:
  - gap_cnt decrements each cycle.
  - when gap_cnt == 1, go to RUN.
  - enable low at any time goes to DRAIN immediately and clears gap_cnt.
- DRAIN transitions:
  - no grants are issued.
  - credits still return.
  - enable high goes to RUN on the next cycle.
- grant_count increments by 1 on every cycle where arb_grant is high.
- The root never holds a grant. The leaf arbiters update their round-robin pointer on each grant, so consecutive grants alternate among competing leaves.

## Timing

- Grant latency: zero cycles.
  - arb_grant is asserted in the same cycle as arb_req, given the grant condition holds.
  - The tree's leaf grant is combinational from arb_grant.
- Credits, state, grant_count and err_overflow update on the rising edge following the event. credits_avail reflects the new value one cycle after a grant or response.
- Throughput:
  - MIN_GAP == 0: one grant per cycle.
  - otherwise: one grant per MIN_GAP+1 cycles.
  - In both cases, further limited by credits and dn_ready.
- Credit-exhaustion recovery: a response at edge N makes a grant possible in cycle N+1, never in cycle N.
- Reset behaviour (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - arb_grant = 0 and dn_valid = 0 immediately on assertion.
  - credits_avail = CREDITS, idle = 1, err_overflow = 0, grant_count = 0.
  - state = RUN, gap_cnt = 0.
- Reset mid-operation discards outstanding credits. Responses arriving after reset for pre-reset requests raise err_overflow; this is the intended behaviour.
- enable falling in the same cycle as a qualifying request: no grant is issued that cycle.

## Test plan

- Reset, CREDITS=4, MIN_GAP=0, arb_req and dn_ready held high, no responses -> arb_grant high for exactly 4 consecutive cycles, then low; credits_avail goes 3,2,1,0; grant_count = 4.
- From credits=0, pulse rsp_valid for 1 cycle -> exactly one grant on the following cycle; credits_avail returns to 0; simultaneous grant and rsp_valid leave credits unchanged.
- MIN_GAP=2, continuous arb_req and dn_ready, responses returned every cycle -> grants on cycles 0, 3, 6, 9; state sequence RUN, GAP, GAP, RUN.
- dn_ready low for 5 cycles with arb_req high -> no grants, credits and grant_count unchanged; grant in the first cycle dn_ready rises.
- enable low during GAP with 2 outstanding -> immediate DRAIN, no grants; two rsp_valid pulses bring idle to 1; enable high -> grant the next cycle.
- rsp_valid at credits == CREDITS -> err_overflow = 1 and stays set, credits_avail stays 4; assert rst mid-burst -> all outputs at reset values asynchronously, err_overflow = 0.
